// File: rtl/mem_stage.sv
// ----------------------------------------------------------------------------
// mem_stage: pipeline stage between execute and writeback.
// Holds one instruction from the execute stage and completes its load. The
// SRAM read data is valid only in the first cycle the instruction is resident,
// so it is captured there and replayed from a hold register while writeback
// stalls. The loaded byte/half/word is extracted and sign- or zero-extended,
// and the result is sent to writeback and, optionally, to decode forwarding.
//
// Build option:
//   MS_FWD_EN  defined   : ms_fwd_bus = {ms_valid && gr_we, dest, final_result}
//              undefined : ms_fwd_bus is tied to zero
// ----------------------------------------------------------------------------
module mem_stage #(
    parameter int unsigned ES_TO_MS_BUS_WD = 76,
    parameter int unsigned MS_TO_WS_BUS_WD = 70,
    parameter int unsigned MS_FWD_BUS_WD   = 38
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [MS_FWD_BUS_WD-1:0]   ms_fwd_bus,
    input  logic [31:0]                data_sram_rdata
);

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned DEST_W    = 5;
    localparam int unsigned LOAD_OP_W = 5;

    // Pipeline state
    logic                       ms_valid_q;
    logic                       ms_valid_d;
    logic [ES_TO_MS_BUS_WD-1:0] es_bus_q;
    logic [ES_TO_MS_BUS_WD-1:0] es_bus_d;
    logic                       first_cyc_q;
    logic                       first_cyc_d;
    logic [DATA_W-1:0]          rdata_hold_q;
    logic [DATA_W-1:0]          rdata_hold_d;

    // Handshake and decoded fields
    logic                       ms_ready_go;
    logic                       load_en;
    logic [LOAD_OP_W-1:0]       load_op;
    logic                       res_from_mem;
    logic                       gr_we;
    logic [DEST_W-1:0]          dest;
    logic [DATA_W-1:0]          alu_result;
    logic [DATA_W-1:0]          pc;

    // Load datapath
    logic [DATA_W-1:0]          mem_word;
    logic [7:0]                 mem_byte;
    logic [15:0]                mem_half;
    logic [DATA_W-1:0]          load_data;
    logic [DATA_W-1:0]          final_result;

    // Field split of the held execute-to-memory bus
    assign load_op      = es_bus_q[75:71];
    assign res_from_mem = es_bus_q[70];
    assign gr_we        = es_bus_q[69];
    assign dest         = es_bus_q[68:64];
    assign alu_result   = es_bus_q[63:32];
    assign pc           = es_bus_q[31:0];

    // Handshake: this stage never needs extra cycles
    assign ms_ready_go    = 1'b1;
    assign ms_allowin     = !ms_valid_q || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid_q && ms_ready_go;
    assign load_en        = es_to_ms_valid && ms_allowin;

    // Next-state for the pipeline register and read-data capture
    always_comb begin
        ms_valid_d   = ms_valid_q;
        es_bus_d     = es_bus_q;
        first_cyc_d  = 1'b0;
        rdata_hold_d = rdata_hold_q;

        if (ms_allowin) begin
            ms_valid_d = es_to_ms_valid;
        end
        if (load_en) begin
            es_bus_d    = es_to_ms_bus;
            first_cyc_d = 1'b1;
        end
        // SRAM data belongs to the resident instruction only in its first cycle
        if (first_cyc_q) begin
            rdata_hold_d = data_sram_rdata;
        end
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid_q   <= 1'b0;
            es_bus_q     <= '0;
            first_cyc_q  <= 1'b0;
            rdata_hold_q <= '0;
        end else begin
            ms_valid_q   <= ms_valid_d;
            es_bus_q     <= es_bus_d;
            first_cyc_q  <= first_cyc_d;
            rdata_hold_q <= rdata_hold_d;
        end
    end

    // Select live SRAM data on entry, held copy while stalled
    assign mem_word = first_cyc_q ? data_sram_rdata : rdata_hold_q;

    // Byte lane chosen by the low two address bits
    always_comb begin
        mem_byte = mem_word[7:0];
        case (alu_result[1:0])
            2'd0:    mem_byte = mem_word[7:0];
            2'd1:    mem_byte = mem_word[15:8];
            2'd2:    mem_byte = mem_word[23:16];
            default: mem_byte = mem_word[31:24];
        endcase
    end

    // Half lane chosen by address bit 1; bit 0 is ignored on half loads
    assign mem_half = alu_result[1] ? mem_word[31:16] : mem_word[15:0];

    // Width and extension per one-hot load opcode
    always_comb begin
        load_data = '0;
        if (load_op[0]) begin
            load_data = mem_word;
        end else if (load_op[1]) begin
            load_data = {{24{mem_byte[7]}}, mem_byte};
        end else if (load_op[2]) begin
            load_data = {{16{mem_half[15]}}, mem_half};
        end else if (load_op[3]) begin
            load_data = {24'b0, mem_byte};
        end else if (load_op[4]) begin
            load_data = {16'b0, mem_half};
        end
    end

    assign final_result = res_from_mem ? load_data : alu_result;

    // Writeback bus
    assign ms_to_ws_bus = {gr_we, dest, final_result, pc};

    // Decode-stage forwarding bus
`ifdef MS_FWD_EN
    assign ms_fwd_bus = {ms_valid_q && gr_we, dest, final_result};
`else
    assign ms_fwd_bus = '0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: a transaction-level model predicts outputs every cycle,
// and directed vectors pin hand-computed results.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ws_allowin;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [75:0] es_to_ms_bus;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic [37:0] ms_fwd_bus;
    logic [31:0] data_sram_rdata;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    localparam logic [4:0] LW  = 5'b00001;
    localparam logic [4:0] LB  = 5'b00010;
    localparam logic [4:0] LH  = 5'b00100;
    localparam logic [4:0] LBU = 5'b01000;
    localparam logic [4:0] LHU = 5'b10000;

    mem_stage dut (
        .clk             (clk),
        .reset           (reset),
        .ws_allowin      (ws_allowin),
        .ms_allowin      (ms_allowin),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_to_ms_bus    (es_to_ms_bus),
        .ms_to_ws_valid  (ms_to_ws_valid),
        .ms_to_ws_bus    (ms_to_ws_bus),
        .ms_fwd_bus      (ms_fwd_bus),
        .data_sram_rdata (data_sram_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [75:0] mkbus(input logic [4:0] op, input logic rfm, input logic we,
                                          input logic [4:0] dst, input logic [31:0] res,
                                          input logic [31:0] pcv);
        return {op, rfm, we, dst, res, pcv};
    endfunction

    // Architectural load result from address, data word and opcode
    function automatic logic [31:0] exp_load(input logic [4:0] op, input logic [31:0] a,
                                             input logic [31:0] d);
        int          bsh = int'(a[1:0]) * 8;
        int          hsh = a[1] ? 16 : 0;
        logic [31:0] b   = (d >> bsh) & 32'h0000_00FF;
        logic [31:0] h   = (d >> hsh) & 32'h0000_FFFF;
        case (op)
            LW:      return d;
            LB:      return b[7] ? (b | 32'hFFFF_FF00) : b;
            LH:      return h[15] ? (h | 32'hFFFF_0000) : h;
            LBU:     return b;
            LHU:     return h;
            default: return 32'h0;
        endcase
    endfunction

    // Model of the single resident instruction
    logic        m_valid = 1'b0;
    logic        m_first = 1'b0;
    logic [75:0] m_bus   = '0;
    logic [31:0] m_data  = '0;

    // Model advance: an instruction enters whenever the slot is free or draining
    always @(posedge clk) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_first <= 1'b0;
            m_bus   <= '0;
        end else if (!m_valid || ws_allowin) begin
            m_valid <= es_to_ms_valid;
            m_first <= es_to_ms_valid;
            if (es_to_ms_valid) m_bus <= es_to_ms_bus;
        end else begin
            m_first <= 1'b0;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        logic [31:0] word;
        logic [31:0] fin;
        if (chk_en) begin
            word = m_first ? data_sram_rdata : m_data;
            if (m_first) m_data <= data_sram_rdata;
            fin = m_bus[70] ? exp_load(m_bus[75:71], m_bus[63:32], word) : m_bus[63:32];
            chk("allowin", 70'(ms_allowin), 70'(!m_valid || ws_allowin));
            chk("ws_valid", 70'(ms_to_ws_valid), 70'(m_valid));
            if (m_valid)
                chk("ws_bus", ms_to_ws_bus, {m_bus[69], m_bus[68:64], fin, m_bus[31:0]});
`ifdef MS_FWD_EN
            chk("fwd_valid", 70'(ms_fwd_bus[37]), 70'(m_valid && m_bus[69]));
            if (m_valid)
                chk("fwd_data", 70'(ms_fwd_bus[36:0]), 70'({m_bus[68:64], fin}));
`else
            chk("fwd_zero", 70'(ms_fwd_bus), 70'(0));
`endif
        end
    end

    // One cycle: drive just after the rising edge, return at the falling edge
    task automatic cyc(input logic rst, input logic v, input logic [75:0] bus,
                       input logic [31:0] rd, input logic wsa);
        @(posedge clk);
        #1;
        reset           = rst;
        es_to_ms_valid  = v;
        es_to_ms_bus    = bus;
        data_sram_rdata = rd;
        ws_allowin      = wsa;
        @(negedge clk);
    endtask

    logic [75:0] alu_bus;

    initial begin
        reset           = 1'b1;
        es_to_ms_valid  = 1'b0;
        es_to_ms_bus    = '0;
        data_sram_rdata = '0;
        ws_allowin      = 1'b0;
        alu_bus         = mkbus(5'b0, 1'b0, 1'b1, 5'd5, 32'h0000_1234, 32'h1c00_0040);

        cyc(1'b1, 1'b0, '0, 32'h0, 1'b0);
        cyc(1'b0, 1'b0, '0, 32'h0, 1'b1);
        chk_en = 1'b1;
        chk("rst_valid", 70'(ms_to_ws_valid), 70'(0));
        chk("rst_allowin", 70'(ms_allowin), 70'(1));
        chk("rst_bus", ms_to_ws_bus, 70'(0));
        chk("rst_fwd", 70'(ms_fwd_bus), 70'(0));

        // Back-to-back loads, each with its own entry-cycle data
        cyc(1'b0, 1'b1, mkbus(LB,  1, 1, 5'd1, 32'h1000_0003, 32'h1c00_0000), 32'h0, 1'b1);
        cyc(1'b0, 1'b1, mkbus(LHU, 1, 1, 5'd2, 32'h1000_0002, 32'h1c00_0004), 32'h80FF_1234, 1'b1);
        chk("lb_res", 70'(ms_to_ws_bus[63:32]), 70'(32'hFFFF_FF80));
        chk("lb_valid", 70'(ms_to_ws_valid), 70'(1));
        cyc(1'b0, 1'b1, mkbus(LH,  1, 1, 5'd3, 32'h1000_0002, 32'h1c00_0008), 32'h8001_7FFF, 1'b1);
        chk("lhu_res", 70'(ms_to_ws_bus[63:32]), 70'(32'h0000_8001));
        cyc(1'b0, 1'b1, mkbus(LW,  1, 1, 5'd4, 32'h1000_0002, 32'h1c00_000c), 32'h8001_7FFF, 1'b1);
        chk("lh_res", 70'(ms_to_ws_bus[63:32]), 70'(32'hFFFF_8001));
        cyc(1'b0, 1'b1, mkbus(LBU, 1, 1, 5'd6, 32'h1000_0001, 32'h1c00_0010), 32'h8001_7FFF, 1'b1);
        chk("lw_res", 70'(ms_to_ws_bus[63:32]), 70'(32'h8001_7FFF));
        cyc(1'b0, 1'b1, mkbus(LW,  1, 1, 5'd7, 32'h0000_0100, 32'h1c00_0014), 32'h0000_A5CC, 1'b1);
        chk("lbu_res", 70'(ms_to_ws_bus[63:32]), 70'(32'h0000_00A5));
        chk("lbu_valid", 70'(ms_to_ws_valid), 70'(1));

        // Stall with changing SRAM data; the ALU op waits upstream
        cyc(1'b0, 1'b1, alu_bus, 32'hDEAD_BEEF, 1'b0);
        chk("stall0_res", 70'(ms_to_ws_bus[63:32]), 70'(32'hDEAD_BEEF));
        chk("stall0_allowin", 70'(ms_allowin), 70'(0));
        for (int i = 1; i < 3; i++) begin
            cyc(1'b0, 1'b1, alu_bus, 32'h1111_1111, 1'b0);
            chk("stall_res", 70'(ms_to_ws_bus[63:32]), 70'(32'hDEAD_BEEF));
            chk("stall_allowin", 70'(ms_allowin), 70'(0));
        end
        cyc(1'b0, 1'b1, alu_bus, 32'h1111_1111, 1'b1);
        chk("drain_res", 70'(ms_to_ws_bus[63:32]), 70'(32'hDEAD_BEEF));
        chk("drain_allowin", 70'(ms_allowin), 70'(1));

        // ALU result passes through and is forwarded
        cyc(1'b0, 1'b0, '0, 32'h5555_5555, 1'b1);
        chk("alu_res", 70'(ms_to_ws_bus[63:32]), 70'(32'h0000_1234));
`ifdef MS_FWD_EN
        chk("alu_fwd", 70'(ms_fwd_bus), 70'({1'b1, 5'd5, 32'h0000_1234}));
`else
        chk("alu_fwd", 70'(ms_fwd_bus), 70'(0));
`endif

        // Reset while a load is stalled
        cyc(1'b0, 1'b1, mkbus(LW, 1, 1, 5'd9, 32'h0000_0200, 32'h1c00_0020), 32'h0, 1'b1);
        cyc(1'b0, 1'b0, '0, 32'hCAFE_F00D, 1'b0);
        chk("pre_rst_res", 70'(ms_to_ws_bus[63:32]), 70'(32'hCAFE_F00D));
        cyc(1'b1, 1'b0, '0, 32'h0, 1'b0);
        cyc(1'b0, 1'b0, '0, 32'h0, 1'b0);
        chk("midrst_valid", 70'(ms_to_ws_valid), 70'(0));
        chk("midrst_allowin", 70'(ms_allowin), 70'(1));

        cyc(1'b0, 1'b0, '0, 32'h0, 1'b1);
        cyc(1'b0, 1'b0, '0, 32'h0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Accepts the execute-to-memory bus.
- Consumes the synchronous data-SRAM read data that returns one cycle after the execute stage issues its request.
- Performs byte/half/word load extraction with sign or zero extension, then forwards the final result to the writeback stage and to the decode-stage forwarding network.

Parameters:
- ES_TO_MS_BUS_WD, 76, width of the incoming bus.
- MS_TO_WS_BUS_WD, 70, width of the outgoing bus.
- MS_FWD_BUS_WD, 38, width of the forwarding bus.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- ws_allowin  input  1  writeback stage can accept.
- ms_allowin  output  1  this stage can accept.
- es_to_ms_valid  input  1  execute stage presents a valid instruction.
- es_to_ms_bus  input  76  {load_op[75:71], res_from_mem[70], gr_we[69], dest[68:64], result[63:32], pc[31:0]}.
- ms_to_ws_valid  output  1  valid to writeback.
- ms_to_ws_bus  output  70  {gr_we[69], dest[68:64], final_result[63:32], pc[31:0]}.
- ms_fwd_bus  output  38  {fwd_valid[37], dest[36:32], final_result[31:0]}.
- data_sram_rdata  input  32  SRAM read data for the request issued in the previous cycle.

Behaviour:
- Handshake:
  - ms_ready_go = 1.
  - ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
  - ms_to_ws_valid = ms_valid && ms_ready_go.
- Pipeline register:
  - On reset: ms_valid <= 0, bus register <= 0.
  - Otherwise, if ms_allowin: ms_valid <= es_to_ms_valid.
  - Bus register loads es_to_ms_bus when es_to_ms_valid && ms_allowin.
- Read-data capture:
  - first_cyc is set to 1 on the cycle the bus register loads, cleared the cycle after.
  - In the first cycle of residence, load data comes from data_sram_rdata, and rdata_hold <= data_sram_rdata.
  - In later cycles (stall because ws_allowin=0), load data comes from rdata_hold, because SRAM rdata then reflects a newer execute-stage request.
  - On reset: first_cyc <= 0, rdata_hold <= 0.
- load_op encoding (one-hot):
  - bit0 ld.w, bit1 ld.b, bit2 ld.h, bit3 ld.bu, bit4 ld.hu.
  - Exactly one bit is set when res_from_mem=1.
- Byte select: result[1:0] picks byte 0..3 (bits 7:0, 15:8, 23:16, 31:24).
- Half select: result[1] picks the lower or upper half. result[0] is ignored; misaligned halves are not trapped.
- Extension:
  - ld.b and ld.h sign-extend.
  - ld.bu and ld.hu zero-extend.
  - ld.w passes all 32 bits.
- final_result = res_from_mem ? extracted load data : result.
- Outputs are combinational from the register state.
  - After reset, ms_to_ws_valid=0 and fwd_valid=0.
  - Bus contents after reset are all-zero.
- Simultaneous events: when an instruction leaves to writeback and a new one enters in the same cycle, first_cyc=1 for the new instruction, and rdata_hold is overwritten with the new data.
- Reset mid-stall discards the held instruction, and no writeback valid is produced.

Optional Feature:
- Macro: MS_FWD_EN.
- Defined: fwd_valid = ms_valid && gr_we, and ms_fwd_bus carries dest and final_result (including load data), so decode can bypass from this stage.
- Undefined: ms_fwd_bus is tied to all zeros, and decode must rely on writeback-stage forwarding or interlock. All other behaviour is unchanged.

Test Plan:
- ld.b, result=0x1000_0003, rdata=0x80FF_1234 on the entry cycle -> final_result=0xFFFF_FF80, and ms_to_ws_valid=1 the same cycle when ws_allowin=1.
- ld.hu, result=...0x2, rdata=0x8001_7FFF -> 0x0000_8001. Same load with ld.h -> 0xFFFF_8001. ld.w -> 0x8001_7FFF.
- Stall: ld.w enters with rdata=0xDEAD_BEEF, ws_allowin=0 for 3 cycles while rdata changes to 0x1111_1111 -> final_result stays 0xDEAD_BEEF, and ms_allowin=0 throughout.
- ALU op (res_from_mem=0, gr_we=1, dest=5, result=0x1234) -> final_result=0x1234. With MS_FWD_EN, ms_fwd_bus={1,5,0x1234}; without it, ms_fwd_bus=0.
- Back-to-back loads with ws_allowin=1 each cycle -> each uses its own entry-cycle rdata, with no bubbles.
- Assert reset during a stalled load -> next cycle ms_valid=0, ms_to_ws_valid=0, ms_allowin=1.
